// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32 datapath: sequences fetch/decode/execute, drives every
// enable and mux select, and bounds each shared-memory handshake with a timeout.
module multicycle_controller #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       memwrite,
   output logic       adrsrc,
   output logic       irwrite,
   output logic       pcwrite,
   output logic       regwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic [2:0] alucontrol,
   output logic       illegal_op,
   output logic       mem_err
);

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL
   } state_t;

   typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} aluop_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

   state_t           state, state_next;
   aluop_t           aluop;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_wait, timeout;
   logic             req_c, wr_c, ir_c, pc_c, rw_c, ill_c;

   assign mem_wait = ((state == FETCH) || (state == MEMREAD) || (state == MEMWRITE)) && !mem_ready;
   assign timeout  = mem_wait && (wait_cnt == LIMIT);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= FETCH;
         wait_cnt <= '0;
      end else begin
         state    <= state_next;
         wait_cnt <= (mem_wait && !timeout) ? wait_cnt + CNT_W'(1) : '0;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next = state;
      aluop      = ALU_ADD;
      req_c      = 1'b0;
      wr_c       = 1'b0;
      ir_c       = 1'b0;
      pc_c       = 1'b0;
      rw_c       = 1'b0;
      ill_c      = 1'b0;
      adrsrc     = 1'b0;
      resultsrc  = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      unique case (state)
         FETCH: begin
            req_c     = 1'b1;
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            ir_c      = mem_ready;
            pc_c      = mem_ready;
            if (mem_ready) state_next = DECODE;
         end
         DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            unique case (op)
               OP_LW, OP_SW: state_next = MEMADR;
               OP_R:         state_next = EXECR;
               OP_I:         state_next = EXECI;
               OP_BEQ:       state_next = BEQ;
               OP_JAL:       state_next = JAL;
               default: begin
                  ill_c      = 1'b1;
                  state_next = FETCH;
               end
            endcase
         end
         MEMADR: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            state_next = op[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            req_c  = 1'b1;
            adrsrc = 1'b1;
            if (mem_ready)    state_next = MEMWB;
            else if (timeout) state_next = FETCH;
         end
         MEMWB: begin
            resultsrc  = 2'b01;
            rw_c       = 1'b1;
            state_next = FETCH;
         end
         MEMWRITE: begin
            req_c  = 1'b1;
            wr_c   = 1'b1;
            adrsrc = 1'b1;
            if (mem_ready || timeout) state_next = FETCH;
         end
         EXECR: begin
            alusrca    = 2'b10;
            aluop      = ALU_FUNCT;
            state_next = ALUWB;
         end
         EXECI: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            aluop      = ALU_FUNCT;
            state_next = ALUWB;
         end
         ALUWB: begin
            rw_c       = 1'b1;
            state_next = FETCH;
         end
         BEQ: begin
            alusrca    = 2'b10;
            aluop      = ALU_SUB;
            pc_c       = zero;
            state_next = FETCH;
         end
         JAL: begin
            alusrca    = 2'b01;
            alusrcb    = 2'b10;
            pc_c       = 1'b1;
            state_next = ALUWB;
         end
         default: state_next = FETCH;
      endcase
   end

   // Strobes are gated by reset so nothing fires while the FSM is held in FETCH.
   assign mem_req    = reset & req_c;
   assign memwrite   = reset & wr_c;
   assign irwrite    = reset & ir_c;
   assign pcwrite    = reset & pc_c;
   assign regwrite   = reset & rw_c;
   assign illegal_op = reset & ill_c;
   assign mem_err    = reset & timeout;

   always_comb begin
      unique case (op)
         OP_SW:   immsrc = 2'b01;
         OP_BEQ:  immsrc = 2'b10;
         OP_JAL:  immsrc = 2'b11;
         default: immsrc = 2'b00;
      endcase
   end

   always_comb begin
      unique case (aluop)
         ALU_ADD: alucontrol = 3'b000;
         ALU_SUB: alucontrol = 3'b001;
         default: begin
            unique case (funct3)
               3'b000:  alucontrol = (op[5] && funct7b5) ? 3'b001 : 3'b000;
               3'b010:  alucontrol = 3'b101;
               3'b110:  alucontrol = 3'b011;
               3'b111:  alucontrol = 3'b010;
               default: alucontrol = 3'b000;
            endcase
         end
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle expectation table for each instruction class
// plus hand sequences for reset, timeout and ready-at-limit corners.
module tb_multicycle_controller;

   typedef struct packed {
      logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite;
      logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
      logic [2:0] alucontrol;
      logic       illegal_op, mem_err;
   } out_t;

   typedef struct {
      string      tag;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z, rdy;
      out_t       exp;
   } row_t;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

   logic       clk = 1'b0, reset = 1'b0;
   logic [6:0] op = RT;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;
   logic       mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, illegal_op, mem_err;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;

   int n_cmp = 0, n_fail = 0;
   row_t rows[$];
   out_t e_rst, e_f1, e_dec, e_ill, e_madr, e_mrd, e_mwb, e_mwr, e_exr, e_exi, e_awb, e_bqt, e_bqn, e_jal;

   always #5 clk = ~clk;

   multicycle_controller #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite), .adrsrc(adrsrc),
      .irwrite(irwrite), .pcwrite(pcwrite), .regwrite(regwrite), .resultsrc(resultsrc),
      .alusrca(alusrca), .alusrcb(alusrcb), .immsrc(immsrc), .alucontrol(alucontrol),
      .illegal_op(illegal_op), .mem_err(mem_err)
   );

   function automatic out_t mk(input logic mr, mw, as, ir, pc, rw,
                               input logic [1:0] rs, sa, sb, input logic il);
      out_t o;
      o = '{mem_req: mr, memwrite: mw, adrsrc: as, irwrite: ir, pcwrite: pc, regwrite: rw,
            resultsrc: rs, alusrca: sa, alusrcb: sb, immsrc: 2'b00, alucontrol: 3'b000,
            illegal_op: il, mem_err: 1'b0};
      return o;
   endfunction

   function automatic out_t cur();
      out_t o;
      o = '{mem_req: mem_req, memwrite: memwrite, adrsrc: adrsrc, irwrite: irwrite,
            pcwrite: pcwrite, regwrite: regwrite, resultsrc: resultsrc, alusrca: alusrca,
            alusrcb: alusrcb, immsrc: immsrc, alucontrol: alucontrol,
            illegal_op: illegal_op, mem_err: mem_err};
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy, input out_t base,
                      input logic [1:0] imm, input logic [2:0] ac);
      row_t r;
      r.tag = tag; r.op = o; r.f3 = f3; r.f7 = f7; r.z = z; r.rdy = rdy;
      r.exp = base;
      r.exp.immsrc = imm;
      r.exp.alucontrol = ac;
      rows.push_back(r);
   endtask

   task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                        input logic z, input logic rdy);
      op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench mid-cycle with the FSM freshly out of reset in FETCH.
   task automatic do_reset(input string name);
      tick();
      op = RT; mem_ready = 1'b1;
      reset = 1'b0;
      #1;
      check({name, " in reset"}, 32'(cur()), 32'(e_rst));
      reset = 1'b1;
   endtask

   task automatic r_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input out_t ex, input logic [2:0] ac);
      add({tag, " fetch"},  o, f3, f7, 1'b0, 1'b1, e_f1,  2'b00, 3'b000);
      add({tag, " decode"}, o, f3, f7, 1'b0, 1'b1, e_dec, 2'b00, 3'b000);
      add({tag, " exec"},   o, f3, f7, 1'b0, 1'b1, ex,    2'b00, ac);
      add({tag, " aluwb"},  o, f3, f7, 1'b0, 1'b1, e_awb, 2'b00, 3'b000);
   endtask

   initial begin
      int pulses;
      e_rst  = mk(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 0);
      e_f1   = mk(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, 0);
      e_dec  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0);
      e_ill  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 1);
      e_madr = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0);
      e_mrd  = mk(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      e_mwb  = mk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0);
      e_mwr  = mk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0);
      e_exr  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
      e_exi  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0);
      e_awb  = mk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 0);
      e_bqt  = mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b10, 2'b00, 0);
      e_bqn  = mk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0);
      e_jal  = mk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 0);

      r_instr("sub", RT, 3'b000, 1'b1, e_exr, 3'b001);
      r_instr("add", RT, 3'b000, 1'b0, e_exr, 3'b000);
      r_instr("or",  RT, 3'b110, 1'b0, e_exr, 3'b011);
      r_instr("slt", RT, 3'b010, 1'b0, e_exr, 3'b101);
      r_instr("andi", IT, 3'b111, 1'b0, e_exi, 3'b010);
      r_instr("addi f7", IT, 3'b000, 1'b1, e_exi, 3'b000);
      r_instr("slli", IT, 3'b001, 1'b0, e_exi, 3'b000);
      add("lw fetch",  LW, 3'b010, 1'b0, 1'b0, 1'b1, e_f1,   2'b00, 3'b000);
      add("lw decode", LW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec,  2'b00, 3'b000);
      add("lw madr",   LW, 3'b010, 1'b0, 1'b0, 1'b1, e_madr, 2'b00, 3'b000);
      for (int i = 0; i < 3; i++)
         add($sformatf("lw wait%0d", i), LW, 3'b010, 1'b0, 1'b0, 1'b0, e_mrd, 2'b00, 3'b000);
      add("lw mread",  LW, 3'b010, 1'b0, 1'b0, 1'b1, e_mrd,  2'b00, 3'b000);
      add("lw memwb",  LW, 3'b010, 1'b0, 1'b0, 1'b1, e_mwb,  2'b00, 3'b000);
      add("sw fetch",  SW, 3'b010, 1'b0, 1'b0, 1'b1, e_f1,   2'b01, 3'b000);
      add("sw decode", SW, 3'b010, 1'b0, 1'b0, 1'b1, e_dec,  2'b01, 3'b000);
      add("sw madr",   SW, 3'b010, 1'b0, 1'b0, 1'b1, e_madr, 2'b01, 3'b000);
      add("sw mwrite", SW, 3'b010, 1'b0, 1'b0, 1'b1, e_mwr,  2'b01, 3'b000);
      add("beq1 fetch",  BQ, 3'b000, 1'b0, 1'b1, 1'b1, e_f1,  2'b10, 3'b000);
      add("beq1 decode", BQ, 3'b000, 1'b0, 1'b1, 1'b1, e_dec, 2'b10, 3'b000);
      add("beq1 taken",  BQ, 3'b000, 1'b0, 1'b1, 1'b1, e_bqt, 2'b10, 3'b001);
      add("beq0 fetch",  BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_f1,  2'b10, 3'b000);
      add("beq0 decode", BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_dec, 2'b10, 3'b000);
      add("beq0 not",    BQ, 3'b000, 1'b0, 1'b0, 1'b1, e_bqn, 2'b10, 3'b001);
      add("jal fetch",  JL, 3'b000, 1'b0, 1'b0, 1'b1, e_f1,  2'b11, 3'b000);
      add("jal decode", JL, 3'b000, 1'b0, 1'b0, 1'b1, e_dec, 2'b11, 3'b000);
      add("jal jal",    JL, 3'b000, 1'b0, 1'b0, 1'b1, e_jal, 2'b11, 3'b000);
      add("jal aluwb",  JL, 3'b000, 1'b0, 1'b0, 1'b1, e_awb, 2'b11, 3'b000);
      add("ill fetch",  BAD, 3'b000, 1'b0, 1'b0, 1'b1, e_f1,  2'b00, 3'b000);
      add("ill decode", BAD, 3'b000, 1'b0, 1'b0, 1'b1, e_ill, 2'b00, 3'b000);
      add("ill refetch", BAD, 3'b000, 1'b0, 1'b0, 1'b1, e_f1, 2'b00, 3'b000);

      // Idle fetch with no ready: one mem_err on the 16th waiting cycle, then FETCH again.
      do_reset("idle");
      pulses = 0;
      for (int i = 0; i < 17; i++) begin
         drive(RT, 3'b000, 1'b0, 1'b0, 1'b0);
         check($sformatf("idle mem_req c%0d", i), 32'(mem_req), 32'd1);
         check($sformatf("idle irwrite/pcwrite c%0d", i), 32'({irwrite, pcwrite}), 32'd0);
         check($sformatf("idle mem_err c%0d", i), 32'(mem_err), 32'(i == 15));
         if (mem_err) pulses++;
         tick();
      end
      check("idle mem_err pulse count", 32'(pulses), 32'd1);

      // Ready on the limit cycle wins over the timeout.
      do_reset("limit");
      for (int i = 0; i < 15; i++) begin
         drive(RT, 3'b000, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(RT, 3'b000, 1'b0, 1'b0, 1'b1);
      check("limit ready fetch", 32'(cur()), 32'(e_f1));
      tick();
      drive(RT, 3'b000, 1'b0, 1'b0, 1'b1);
      check("limit then decode", 32'(cur()), 32'(e_dec));

      do_reset("table");
      foreach (rows[i]) begin
         drive(rows[i].op, rows[i].f3, rows[i].f7, rows[i].z, rows[i].rdy);
         check(rows[i].tag, 32'(cur()), 32'(rows[i].exp));
         tick();
      end

      // Store that never gets ready: times out in MEMWRITE and refetches.
      do_reset("swto");
      drive(SW, 3'b010, 1'b0, 1'b0, 1'b1); tick();
      drive(SW, 3'b010, 1'b0, 1'b0, 1'b1); tick();
      drive(SW, 3'b010, 1'b0, 1'b0, 1'b1); tick();
      for (int i = 0; i < 16; i++) begin
         drive(SW, 3'b010, 1'b0, 1'b0, 1'b0);
         check($sformatf("swto memwrite c%0d", i), 32'({mem_req, memwrite, regwrite}), 32'b110);
         check($sformatf("swto mem_err c%0d", i), 32'(mem_err), 32'(i == 15));
         tick();
      end
      drive(SW, 3'b010, 1'b0, 1'b0, 1'b1);
      e_f1.immsrc = 2'b01;
      check("swto refetch", 32'(cur()), 32'(e_f1));

      // Reset dropped during MEMWB kills regwrite at once and returns to FETCH.
      do_reset("midrst");
      drive(LW, 3'b010, 1'b0, 1'b0, 1'b1); tick();
      drive(LW, 3'b010, 1'b0, 1'b0, 1'b1); tick();
      drive(LW, 3'b010, 1'b0, 1'b0, 1'b1); tick();
      drive(LW, 3'b010, 1'b0, 1'b0, 1'b1); tick();
      drive(LW, 3'b010, 1'b0, 1'b0, 1'b1);
      check("midrst memwb regwrite", 32'(regwrite), 32'd1);
      reset = 1'b0;
      #1;
      check("midrst in reset", 32'(cur()), 32'(e_rst));
      reset = 1'b1;
      #1;
      e_f1.immsrc = 2'b00;
      check("midrst back in fetch", 32'(cur()), 32'(e_f1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
